// File: rtl/snn_seq_pkg.sv
// Shared opcodes, FSM state encoding and opcode decode for the SNN host sequencer.
package snn_seq_pkg;

    localparam logic [1:0] OP_LOAD_W = 2'b00;
    localparam logic [1:0] OP_LOAD_I = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_I  = 3'd2,
        S_RUN_LEN = 3'd3,
        S_RUN     = 3'd4,
        S_READ    = 3'd5
    } state_t;

    // Map a command opcode to the state that services it.
    function automatic state_t op_to_state(input logic [1:0] op);
        case (op)
            OP_LOAD_W: return S_LOAD_W;
            OP_LOAD_I: return S_LOAD_I;
            OP_RUN:    return S_RUN_LEN;
            default:   return S_READ;
        endcase
    endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// Per-output saturating spike counter; clear has priority over increment.
module snn_spike_counter #(
    parameter int COUNT_BITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clr,
    input  logic                  i_inc_en,
    input  logic                  i_spike,
    output logic [COUNT_BITS-1:0] o_count
);

    logic [COUNT_BITS-1:0] r_count;

    // Count spikes on execute cycles, sticking at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr)
            r_count <= '0;
        else if (i_inc_en && i_spike && (r_count != '1))
            r_count <= r_count + COUNT_BITS'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/snn_host_sequencer.sv
// Host-side sequencer for the LIF spiking core: parses a byte command stream,
// streams weight/input bytes into the core load path, runs N ticks while
// counting output spikes, and streams the counts back.
// Optional feature macro: SNN_SEQ_AUTO_READ_EN (a completed RUN with N>0
// streams the counts without a READ command).
module snn_host_sequencer
    import snn_seq_pkg::*;
#(
    parameter int INPUTS     = 16,
    parameter int WEIGHTS    = 640,
    parameter int OUTPUTS    = 8,
    parameter int COUNT_BITS = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_in_data,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic [7:0]         o_out_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [7:0]         o_core_data,
    output logic               o_core_load,
    output logic               o_core_input_weights,
    output logic               o_core_execute,
    input  logic [OUTPUTS-1:0] i_core_spikes,
    output logic               o_busy
);

    localparam int W_BYTES = WEIGHTS / 8;
    localparam int I_BYTES = INPUTS / 8;
    localparam int BC_W    = $clog2(W_BYTES + 1);
    localparam int RD_W    = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    state_t                              r_state, w_next;
    logic [BC_W-1:0]                     r_bcnt;
    logic [7:0]                          r_run_len, r_run_cnt;
    logic [RD_W-1:0]                     r_rd_idx;
    logic                                r_core_load, r_core_wsel;
    logic [7:0]                          r_core_data;
    logic [OUTPUTS-1:0][COUNT_BITS-1:0]  w_counts;
    logic [COUNT_BITS+7:0]               w_ext;
    logic [BC_W-1:0]                     w_load_len;
    logic                                w_in_acc, w_out_acc, w_is_load;
    logic                                w_load_last, w_run_last, w_rd_last, w_clr;

    assign w_in_acc    = i_in_valid && o_in_ready;
    assign w_out_acc   = o_out_valid && i_out_ready;
    assign w_is_load   = (r_state == S_LOAD_W) || (r_state == S_LOAD_I);
    assign w_load_len  = (r_state == S_LOAD_W) ? BC_W'(W_BYTES) : BC_W'(I_BYTES);
    assign w_load_last = (r_bcnt == w_load_len - BC_W'(1));
    assign w_run_last  = (r_run_cnt == r_run_len - 8'd1);
    assign w_rd_last   = (r_rd_idx == RD_W'(OUTPUTS - 1));
    assign w_clr       = (r_state == S_RUN_LEN) && w_in_acc;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_in_acc) w_next = op_to_state(i_in_data[7:6]);
            S_LOAD_W,
            S_LOAD_I:  if (w_in_acc && w_load_last) w_next = S_IDLE;
            S_RUN_LEN: if (w_in_acc) w_next = (i_in_data == 8'd0) ? S_IDLE : S_RUN;
`ifdef SNN_SEQ_AUTO_READ_EN
            S_RUN:     if (w_run_last) w_next = S_READ;
`else
            S_RUN:     if (w_run_last) w_next = S_IDLE;
`endif
            S_READ:    if (w_out_acc && w_rd_last) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; count bytes are zero-extended or truncated to 8 bits.
    always_comb begin
        w_ext          = {8'd0, w_counts[r_rd_idx]};
        o_in_ready     = (r_state == S_IDLE) || w_is_load || (r_state == S_RUN_LEN);
        o_core_execute = (r_state == S_RUN);
        o_out_valid    = (r_state == S_READ);
        o_out_data     = (r_state == S_READ) ? w_ext[7:0] : 8'd0;
        o_busy         = (r_state != S_IDLE);
    end

    // Load strobe: each accepted payload byte is presented to the core for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_core_load <= 1'b0;
            r_core_data <= 8'd0;
            r_core_wsel <= 1'b0;
            r_bcnt      <= '0;
        end else begin
            r_core_load <= 1'b0;
            if (w_is_load && w_in_acc) begin
                r_core_load <= 1'b1;
                r_core_data <= i_in_data;
                r_core_wsel <= (r_state == S_LOAD_W);
                r_bcnt      <= w_load_last ? '0 : r_bcnt + BC_W'(1);
            end
        end
    end

    // Run length / tick counter and readout index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run_len <= 8'd0;
            r_run_cnt <= 8'd0;
            r_rd_idx  <= '0;
        end else begin
            if (w_clr) begin
                r_run_len <= i_in_data;
                r_run_cnt <= 8'd0;
            end else if (r_state == S_RUN) begin
                r_run_cnt <= r_run_cnt + 8'd1;
            end
            if (w_out_acc)
                r_rd_idx <= w_rd_last ? '0 : r_rd_idx + RD_W'(1);
        end
    end

    assign o_core_load          = r_core_load;
    assign o_core_data          = r_core_data;
    assign o_core_input_weights = r_core_wsel;

    for (genvar k = 0; k < OUTPUTS; k++) begin : g_cnt
        snn_spike_counter #(.COUNT_BITS(COUNT_BITS)) u_cnt (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_clr   (w_clr),
            .i_inc_en(o_core_execute),
            .i_spike (i_core_spikes[k]),
            .o_count (w_counts[k])
        );
    end

endmodule

// File: tb/tb_snn_host_sequencer.sv
// Randomized self-checking bench for snn_host_sequencer. Two instances share
// all stimulus: COUNT_BITS=8 and COUNT_BITS=4 (for saturation). Expected
// strobes and spike counts come from a byte list and min(N, 2^CB-1) arithmetic.
module tb_snn_host_sequencer;

    localparam int OUTPUTS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, out_ready;
    logic [OUTPUTS-1:0] core_spikes;

    logic       a_in_ready, a_out_valid, a_core_load, a_core_wsel, a_core_exec, a_busy;
    logic [7:0] a_out_data, a_core_data;
    logic       b_in_ready, b_out_valid, b_core_load, b_core_wsel, b_core_exec, b_busy;
    logic [7:0] b_out_data, b_core_data;

    always #5 clk = ~clk;

    snn_host_sequencer #(.COUNT_BITS(8)) u_dut8 (
        .i_clk(clk), .i_reset(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(a_in_ready), .o_out_data(a_out_data), .o_out_valid(a_out_valid),
        .i_out_ready(out_ready), .o_core_data(a_core_data), .o_core_load(a_core_load),
        .o_core_input_weights(a_core_wsel), .o_core_execute(a_core_exec),
        .i_core_spikes(core_spikes), .o_busy(a_busy));

    snn_host_sequencer #(.COUNT_BITS(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(b_in_ready), .o_out_data(b_out_data), .o_out_valid(b_out_valid),
        .i_out_ready(out_ready), .o_core_data(b_core_data), .o_core_load(b_core_load),
        .o_core_input_weights(b_core_wsel), .o_core_execute(b_core_exec),
        .i_core_spikes(core_spikes), .o_busy(b_busy));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference spike counts for the 8-bit and 4-bit instances.
    int m8[OUTPUTS];
    int m4[OUTPUTS];

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    // Observed core activity (monitor is the only writer).
    logic [8:0] strb_q[$];
    int         ex_cnt  = 0;
    int         ex_runs = 0;
    logic       prev_ex = 1'b0;

    always @(negedge clk) begin
        if (a_core_load) strb_q.push_back({a_core_wsel, a_core_data});
        if (a_core_exec && !prev_ex) ex_runs++;
        if (a_core_exec) ex_cnt++;
        if (a_core_load && a_core_exec) chk("load_exec_excl", 1, 0);
        prev_ex = a_core_exec;
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!a_in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic do_load(input bit is_w, input logic [7:0] bytes[$], input bit gaps);
        int base;
        base = strb_q.size();
        send_byte(is_w ? {2'b00, 6'($urandom)} : {2'b01, 6'($urandom)});
        @(negedge clk);
        chk("load_busy", a_busy, 1);
        foreach (bytes[i]) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(bytes[i]);
        end
        @(negedge clk);
        chk("load_busy_done", a_busy, 0);
        @(negedge clk);
        chk("load_strobes", strb_q.size() - base, bytes.size());
        foreach (bytes[i])
            if (base + i < strb_q.size())
                chk("load_byte", strb_q[base + i], {is_w, bytes[i]});
    endtask

    task automatic read_stream(input bit send_cmd, input bit rnd_ready);
        int k, t;
        k = 0;
        t = 0;
        if (send_cmd) send_byte({2'b11, 6'($urandom)});
        while (k < OUTPUTS && t < 2000) begin
            @(negedge clk);
            t++;
            out_ready = rnd_ready ? 1'($urandom) : 1'b1;
            if (a_out_valid) begin
                chk("rd_cnt8", a_out_data, m8[k]);
                chk("rd_cnt4", b_out_data, m4[k]);
                if (out_ready) k++;
            end
        end
        if (k < OUTPUTS) chk("rd_timeout", k, OUTPUTS);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rd_done_valid", a_out_valid, 0);
        chk("rd_done_busy", a_busy, 0);
    endtask

    task automatic run_cmd(input int n, input logic [OUTPUTS-1:0] sp);
        int bc, br, t;
        core_spikes = sp;
        send_byte({2'b10, 6'($urandom)});
        bc = ex_cnt;
        br = ex_runs;
        send_byte(8'(n));
        @(negedge clk);
        if (a_core_exec) chk("run_in_ready", a_in_ready, 0);
        t = 0;
        while (a_core_exec && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("exec_cycles", ex_cnt - bc, n);
        chk("exec_runs", ex_runs - br, (n > 0) ? 1 : 0);
        for (int k = 0; k < OUTPUTS; k++) begin
            m8[k] = sp[k] ? sat(n, 255) : 0;
            m4[k] = sp[k] ? sat(n, 15) : 0;
        end
    endtask

    task automatic run_and_read(input int n, input logic [OUTPUTS-1:0] sp, input bit rnd_ready);
        run_cmd(n, sp);
`ifdef SNN_SEQ_AUTO_READ_EN
        read_stream(n == 0, rnd_ready);
`else
        read_stream(1'b1, rnd_ready);
`endif
    endtask

    initial begin
        logic [7:0] bq[$];
        int t;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0; core_spikes = '0;
        for (int k = 0; k < OUTPUTS; k++) begin m8[k] = 0; m4[k] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_core_load", a_core_load, 0);
        chk("rst_core_exec", a_core_exec, 0);
        chk("rst_core_data", a_core_data, 0);
        chk("rst_core_wsel", a_core_wsel, 0);

        read_stream(1'b1, 1'b0);

        bq = '{8'hA5, 8'h3C};
        do_load(1'b0, bq, 1'b0);

        bq.delete();
        for (int i = 0; i < 80; i++) bq.push_back(8'($urandom));
        do_load(1'b1, bq, 1'b1);

        run_and_read(5, 8'h01, 1'b0);
        read_stream(1'b1, 1'b1);
        run_and_read(255, 8'hFF, 1'b1);
        run_and_read(0, 8'($urandom), 1'b0);

        for (int it = 0; it < 6; it++) begin
            bq.delete();
            for (int i = 0; i < 2; i++) bq.push_back(8'($urandom));
            do_load(1'b0, bq, 1'b1);
            run_and_read($urandom_range(1, 40), 8'($urandom), 1'b1);
        end

        // Reset in the middle of a readout.
        send_byte(8'hC0);
        t = 0;
        while (!a_out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("midrd_valid", a_out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrd_out_valid", a_out_valid, 0);
        chk("midrd_busy", a_busy, 0);
        chk("midrd_in_ready", a_in_ready, 1);
        for (int k = 0; k < OUTPUTS; k++) begin m8[k] = 0; m4[k] = 0; end
        read_stream(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
